// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between a controller and the
// bit-serial add/subtract sequencer.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer driving one external
// full-adder cell, LSB first, carry held in a flop.
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus,
  output logic                fa_x,
  output logic                fa_y,
  output logic                fa_cin,
  input  logic                fa_sum,
  input  logic                fa_cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    fa_x         = 1'b0;
    fa_y         = 1'b0;
    fa_cin       = 1'b0;
    sum_nxt      = sum_reg;
    sum_nxt[idx] = fa_sum;
    last         = (idx == IW'(WIDTH - 1));
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        fa_x     = a_reg[idx];
        fa_y     = b_reg[idx];
        fa_cin   = carry;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at latch, seed carry with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      carry        <= 1'b0;
      idx          <= '0;
      bus.result   <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg <= bus.a;
            b_reg <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg <= sum_nxt;
          carry   <= fa_cout;
          idx     <= idx + IW'(1);
          if (last) begin
            bus.result   <= sum_nxt;
            bus.cout     <= fa_cout;
            bus.overflow <= carry ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl with a behavioural
// full-adder cell and an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  logic clk;
  logic rst;
  logic fa_x;
  logic fa_y;
  logic fa_cin;
  logic fa_sum;
  logic fa_cout;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .fa_x    (fa_x),
    .fa_y    (fa_y),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
  );

  assign fa_sum  = fa_x ^ fa_y ^ fa_cin;
  assign fa_cout = (fa_x & fa_y) | (fa_cin & (fa_x ^ fa_y));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      tests  = 0;
  int      fails  = 0;
  int      issued = 0;
  int      seen   = 0;
  bit      armed  = 0;
  exp_t    q[$];
  realtime done_t[$];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int ai, input int bi,
                                 input bit s, input bit c);
    exp_t e;
    int m;
    int h;
    int sa;
    int sb;
    int u;
    int sv;
    m  = 1 << W;
    h  = 1 << (W - 1);
    sa = (ai >= h) ? ai - m : ai;
    sb = (bi >= h) ? bi - m : bi;
    if (!s) begin
      u   = ai + bi + int'(c);
      sv  = sa + sb + int'(c);
      e.c = (u >= m);
    end else begin
      u   = ai - bi + m;
      sv  = sa - sb;
      e.c = (ai >= bi);
    end
    e.r = W'(u % m);
    e.o = (sv > h - 1) || (sv < -h);
    return e;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", int'(n < 100), 1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit s, input bit c, input bit push);
    wait_idle();
    bus.a     = a;
    bus.b     = b;
    bus.sub   = s;
    bus.cin   = c;
    bus.start = 1'b1;
    @(posedge clk);
    if (push) begin
      q.push_back(model(int'(a), int'(b), s, c));
      issued++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.sub   = 1'($urandom);
    bus.cin   = 1'($urandom);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (armed && !rst) begin
        if (!bus.busy)
          chk("fa_idle_zero", int'({fa_x, fa_y, fa_cin}), 0);
        if (bus.done) begin
          done_t.push_back($realtime);
          seen++;
          chk("done_expected", int'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("result", int'(bus.result), int'(e.r));
            chk("cout", int'(bus.cout), int'(e.c));
            chk("overflow", int'(bus.overflow), int'(e.o));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] xs;
    int n;
    int k;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_cout", int'(bus.cout), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_fa", int'({fa_x, fa_y, fa_cin}), 0);
    rst   = 1'b0;
    armed = 1'b1;

    issue(4'd5, 4'd3, 1'b0, 1'b0, 1'b1);
    xs = '0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      xs[i] = fa_x;
      chk("run_busy", int'(bus.busy), 1);
    end
    chk("fa_x_seq", int'(xs), 5);
    @(negedge clk);
    chk("done_after_run", int'({bus.busy, bus.done}), 1);
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);

    issue(4'd15, 4'd1, 1'b0, 1'b0, 1'b1);
    issue(4'd7, 4'd7, 1'b0, 1'b1, 1'b1);
    issue(4'd3, 4'd5, 1'b1, 1'b0, 1'b1);
    issue(4'd8, 4'd1, 1'b1, 1'b1, 1'b1);

    issue(4'd9, 4'd4, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    wait_idle();
    bus.a     = 4'd6;
    bus.b     = 4'd2;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q.push_back(model(6, 2, 1'b0, 1'b0));
      issued++;
    end
    repeat (2 * (W + 2) + 1) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    k = done_t.size();
    if (k >= 3) begin
      chk("b2b_gap1", int'(done_t[k-2] - done_t[k-3]), (W + 2) * 10);
      chk("b2b_gap2", int'(done_t[k-1] - done_t[k-2]), (W + 2) * 10);
    end else begin
      chk("b2b_done_count", k, 3);
    end

    issue(4'd11, 4'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_result", int'(bus.result), 0);
    chk("midrst_cout", int'(bus.cout), 0);
    chk("midrst_ovf", int'(bus.overflow), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("midrst_no_done", int'(bus.done), 0);
    end
    issue(4'd11, 4'd6, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(v[3:0], v[7:4], v[8], 1'($urandom), 1'b1);
    end

    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    chk("done_count", seen, issued);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
